tick_timer: RTL and testbench



---
 rtl/pong_pkg.sv | 8 +
 rtl/tick_timer_period_calc.sv | 27 ++
 rtl/tick_timer.sv | 94 +++++++++
 tb/tb_tick_timer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong timing constants used by the datapath and the controller bench.
package pong_pkg;

   localparam int CNT_W          = 26;
   localparam int MAX_PERIOD_DEF = 25_000_000;
   localparam int MIN_PERIOD_DEF = 2_500_000;

endpackage

// File: rtl/tick_timer_period_calc.sv
// Next tick period after one speed-up step, clamped to the floor.
module tick_period_calc #(
   parameter int CNT_W      = 26,
   parameter int MIN_PERIOD = 2_500_000,
   parameter int STEP_SHIFT = 3
) (
   input  logic [CNT_W-1:0] period_i,
   output logic [CNT_W-1:0] nxt_o,
   output logic             changed_o
);

   localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

   logic [CNT_W-1:0] step;
   logic [CNT_W-1:0] diff;

   always_comb begin
      step = period_i >> STEP_SHIFT;
      if (step == '0) begin
         step = CNT_W'(1);
      end
      diff  = period_i - step;
      nxt_o = (diff < MIN_P) ? MIN_P : diff;
      changed_o = (nxt_o != period_i);
   end

endmodule

// File: rtl/tick_timer.sv
// Game-speed tick generator: down-paced TICK whose period shrinks per return.
module tick_timer #(
   parameter int CNT_W      = pong_pkg::CNT_W,
   parameter int MAX_PERIOD = pong_pkg::MAX_PERIOD_DEF,
   parameter int MIN_PERIOD = pong_pkg::MIN_PERIOD_DEF,
   parameter int STEP_SHIFT = 3,
   parameter int LVL_W      = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             MAXTIME,
   input  logic             SETTIME,
   output logic             TICK,
   output logic [CNT_W-1:0] PERIOD,
   output logic [LVL_W-1:0] LEVEL
);

   if (MIN_PERIOD < 2 || MIN_PERIOD > MAX_PERIOD ||
       (longint'(MAX_PERIOD) >> CNT_W) != 0) begin : g_bad_period
      $fatal(1, "tick_timer: illegal MIN/MAX_PERIOD for CNT_W");
   end
   if (STEP_SHIFT < 1) begin : g_bad_shift
      $fatal(1, "tick_timer: STEP_SHIFT must be >= 1");
   end

   localparam logic [CNT_W-1:0] MAX_P = CNT_W'(MAX_PERIOD);

   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             tick_q, tick_d;
   logic [CNT_W-1:0] nxt;
   logic             changed;

   tick_period_calc #(
      .CNT_W     (CNT_W),
      .MIN_PERIOD(MIN_PERIOD),
      .STEP_SHIFT(STEP_SHIFT)
   ) u_calc (
      .period_i (period_q),
      .nxt_o    (nxt),
      .changed_o(changed)
   );

   always_comb begin
      period_d = period_q;
      cnt_d    = cnt_q;
      level_d  = level_q;
      tick_d   = 1'b0;
      priority case (1'b1)
         MAXTIME: begin
            period_d = MAX_P;
            cnt_d    = '0;
            level_d  = '0;
         end
         SETTIME: begin
            period_d = nxt;
            cnt_d    = '0;
            if (changed && level_q != '1) begin
               level_d = level_q + LVL_W'(1);
            end
         end
         EN: begin
            if (cnt_q == period_q - CNT_W'(1)) begin
               cnt_d  = '0;
               tick_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         period_q <= MAX_P;
         cnt_q    <= '0;
         level_q  <= '0;
         tick_q   <= 1'b0;
      end else begin
         period_q <= period_d;
         cnt_q    <= cnt_d;
         level_q  <= level_d;
         tick_q   <= tick_d;
      end
   end

   assign TICK   = tick_q;
   assign PERIOD = period_q;
   assign LEVEL  = level_q;

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer with small periods.
module tb_tick_timer;

   localparam int MAXP = 16;
   localparam int MINP = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       EN = 1'b0;
   logic       MAXTIME = 1'b0;
   logic       SETTIME = 1'b0;
   logic       TICK;
   logic [7:0] PERIOD;
   logic [3:0] LEVEL;

   tick_timer #(
      .CNT_W     (8),
      .MAX_PERIOD(MAXP),
      .MIN_PERIOD(MINP),
      .STEP_SHIFT(2),
      .LVL_W     (4)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .EN     (EN),
      .MAXTIME(MAXTIME),
      .SETTIME(SETTIME),
      .TICK   (TICK),
      .PERIOD (PERIOD),
      .LEVEL  (LEVEL)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic t;
      int   p;
      int   l;
   } exp_t;

   typedef struct {
      logic en;
      logic mx;
      logic st;
      int   n;
      int   ticks;
      int   p;
      int   l;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[15];

   int tests = 0;
   int failed = 0;
   int m_p = MAXP, m_c = 0, m_l = 0;
   logic m_t = 1'b0;
   logic last_tick;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference behaviour of one clock edge.
   task automatic model(input logic en, mx, st, rs);
      int step, n;
      m_t = 1'b0;
      if (rs || mx) begin
         m_p = MAXP;
         m_c = 0;
         if (rs || mx) m_l = 0;
      end else if (st) begin
         step = m_p / 4;
         if (step == 0) step = 1;
         n = m_p - step;
         if (n < MINP) n = MINP;
         if (n != m_p && m_l < 15) m_l++;
         m_p = n;
         m_c = 0;
      end else if (en) begin
         if (m_c + 1 == m_p) begin
            m_c = 0;
            m_t = 1'b1;
         end else begin
            m_c++;
         end
      end
   endtask

   task automatic cyc(input logic en, mx, st, rs);
      exp_t e;
      EN = en;
      MAXTIME = mx;
      SETTIME = st;
      RST = rs;
      model(en, mx, st, rs);
      e.t = m_t;
      e.p = m_p;
      e.l = m_l;
      sb.push_back(e);
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      tests++;
      if ({TICK, PERIOD, LEVEL} !== {e.t, 8'(e.p), 4'(e.l)}) begin
         failed++;
         $display("FAIL sb: tick/period/level %b/%0d/%0d expected %b/%0d/%0d",
                  TICK, PERIOD, LEVEL, e.t, e.p, e.l);
      end
      last_tick = TICK;
   endtask

   task automatic wait_tick(input int lim, output int idx);
      idx = -1;
      for (int i = 1; i <= lim; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0);
         if (last_tick) begin
            idx = i;
            break;
         end
      end
   endtask

   task automatic run(input logic en, mx, st, input int n,
                      output int ticks, output int first, output int second);
      ticks = 0;
      first = -1;
      second = -1;
      for (int i = 1; i <= n; i++) begin
         cyc(en, mx, st, 1'b0);
         if (last_tick) begin
            ticks++;
            if (ticks == 1) first = i;
            if (ticks == 2) second = i;
         end
      end
   endtask

   initial begin
      int tk, f, s, idx;
      tbl = '{
         '{1'b1, 1'b0, 1'b0, 40, 2, 16, 0},
         '{1'b1, 1'b0, 1'b1, 1, 0, 12, 1},
         '{1'b1, 1'b0, 1'b0, 19, 1, 12, 1},
         '{1'b1, 1'b0, 1'b1, 1, 0, 9, 2},
         '{1'b1, 1'b0, 1'b0, 19, 2, 9, 2},
         '{1'b1, 1'b0, 1'b1, 1, 0, 7, 3},
         '{1'b1, 1'b0, 1'b0, 19, 2, 7, 3},
         '{1'b1, 1'b0, 1'b1, 1, 0, 6, 4},
         '{1'b1, 1'b0, 1'b0, 19, 3, 6, 4},
         '{1'b1, 1'b0, 1'b1, 1, 0, 5, 5},
         '{1'b1, 1'b0, 1'b0, 19, 3, 5, 5},
         '{1'b1, 1'b0, 1'b1, 1, 0, 4, 6},
         '{1'b1, 1'b0, 1'b0, 19, 4, 4, 6},
         '{1'b1, 1'b0, 1'b1, 1, 0, 4, 6},
         '{1'b1, 1'b0, 1'b0, 19, 4, 4, 6}
      };

      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_tick", int'(TICK), 0);
      chk("rst_period", int'(PERIOD), 16);
      chk("rst_level", int'(LEVEL), 0);

      foreach (tbl[i]) begin
         run(tbl[i].en, tbl[i].mx, tbl[i].st, tbl[i].n, tk, f, s);
         chk($sformatf("row%0d_ticks", i), tk, tbl[i].ticks);
         chk($sformatf("row%0d_period", i), int'(PERIOD), tbl[i].p);
         chk($sformatf("row%0d_level", i), int'(LEVEL), tbl[i].l);
         if (i == 0) begin
            chk("first_tick_cycle", f, 16);
            chk("second_tick_cycle", s, 32);
         end
      end

      // Mid-count SETTIME at period 9, cnt 5.
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("mid_period9", int'(PERIOD), 9);
      run(1'b1, 1'b0, 1'b0, 5, tk, f, s);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("mid_strobe_tick", int'(TICK), 0);
      chk("mid_period7", int'(PERIOD), 7);
      wait_tick(30, idx);
      chk("mid_next_tick", idx, 7);

      // Strobe on the terminal count suppresses the tick.
      run(1'b1, 1'b0, 1'b0, 6, tk, f, s);
      chk("term_no_early_tick", tk, 0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("term_tick_suppressed", int'(TICK), 0);
      chk("term_period6", int'(PERIOD), 6);
      wait_tick(30, idx);
      chk("term_next_tick", idx, 6);

      // MAXTIME wins over SETTIME at period 5.
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("both_pre_period", int'(PERIOD), 5);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      chk("both_period", int'(PERIOD), 16);
      chk("both_level", int'(LEVEL), 0);
      wait_tick(40, idx);
      chk("both_next_tick", idx, 16);

      // MAXTIME held: no ticks at all.
      run(1'b1, 1'b1, 1'b0, 50, tk, f, s);
      chk("maxhold_ticks", tk, 0);
      wait_tick(40, idx);
      chk("maxhold_release_tick", idx, 16);

      // EN low freezes the count at 8.
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      run(1'b1, 1'b0, 1'b0, 8, tk, f, s);
      run(1'b0, 1'b0, 1'b0, 10, tk, f, s);
      chk("en_low_ticks", tk, 0);
      wait_tick(40, idx);
      chk("en_resume_tick", idx, 8);

      // Synchronous reset mid-count.
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("prerst_level", int'(LEVEL), 1);
      run(1'b1, 1'b0, 1'b0, 5, tk, f, s);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      chk("midrst_tick", int'(TICK), 0);
      chk("midrst_period", int'(PERIOD), 16);
      chk("midrst_level", int'(LEVEL), 0);
      wait_tick(40, idx);
      chk("midrst_next_tick", idx, 16);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
